// File: rtl/sr_rx_checker.sv
// sr_rx_checker: serial word receiver with sync-word alignment.
// In HUNT it searches every bit position for the sync word. In LOCKED it
// assembles 4-bit words into a 64-word frame. Each word is written to the
// capture port and compared with the expected data. Lock is dropped after
// MISS_LIMIT consecutive bad sync words.
module sr_rx_checker #(
  parameter logic [3:0] SYNC_WORD  = 4'hA,
  parameter int         MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  input  logic        ser_valid,
  input  logic [3:0]  exp_data,
  input  logic        err_clr,
  output logic [5:0]  exp_addr,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [3:0]  wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        lock_lost,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t        r_state,     w_stateNext;
  logic [3:0]    r_win,       w_winNext;
  logic [1:0]    r_bitCnt,    w_bitCntNext;
  logic [5:0]    r_addr,      w_addrNext;
  logic [MW-1:0] r_miss,      w_missNext;
  logic          r_wrEn,      w_wrEnNext;
  logic [5:0]    r_wrAddr,    w_wrAddrNext;
  logic [3:0]    r_wrData,    w_wrDataNext;
  logic          r_frameDone, w_frameDoneNext;
  logic          r_lockLost,  w_lockLostNext;
  logic [15:0]   r_errCnt,    w_errCntNext;
  logic [15:0]   r_frameCnt,  w_frameCntNext;

  logic [3:0]    w_shift;
  logic [MW-1:0] w_missInc;
  logic          w_emit;
  logic [5:0]    w_emitAddr;

  assign w_shift   = {ser_in, r_win[3:1]};
  assign w_missInc = r_miss + 1'b1;

  // Next-state logic: alignment FSM, word assembly, capture port and counters.
  always_comb begin
    w_stateNext     = r_state;
    w_winNext       = r_win;
    w_bitCntNext    = r_bitCnt;
    w_addrNext      = r_addr;
    w_missNext      = r_miss;
    w_wrEnNext      = 1'b0;
    w_wrAddrNext    = r_wrAddr;
    w_wrDataNext    = r_wrData;
    w_frameDoneNext = 1'b0;
    w_lockLostNext  = 1'b0;
    w_errCntNext    = r_errCnt;
    w_frameCntNext  = r_frameCnt;
    w_emit          = 1'b0;
    w_emitAddr      = r_addr;

    if (ser_valid) begin
      w_winNext = w_shift;
      case (r_state)
        HUNT: begin
          if (w_shift == SYNC_WORD) begin
            w_stateNext  = LOCKED;
            w_bitCntNext = 2'd0;
            w_addrNext   = 6'd1;
            w_missNext   = '0;
            w_emit       = 1'b1;
            w_emitAddr   = 6'd0;
          end
        end
        LOCKED: begin
          w_bitCntNext = r_bitCnt + 2'd1;
          if (r_bitCnt == 2'd3) begin
            w_emit     = 1'b1;
            w_addrNext = r_addr + 6'd1;
            if (r_addr == 6'd0) begin
              if (w_shift == SYNC_WORD) begin
                w_missNext = '0;
              end else if (w_missInc == MW'(MISS_LIMIT)) begin
                w_stateNext    = HUNT;
                w_lockLostNext = 1'b1;
                w_missNext     = '0;
                w_addrNext     = 6'd0;
              end else begin
                w_missNext = w_missInc;
              end
            end
            if (r_addr == 6'd63) begin
              w_frameDoneNext = 1'b1;
              w_frameCntNext  = r_frameCnt + 16'd1;
            end
          end
        end
        default: w_stateNext = HUNT;
      endcase

      if (w_emit) begin
        w_wrEnNext   = 1'b1;
        w_wrAddrNext = w_emitAddr;
        w_wrDataNext = w_shift;
        if ((w_shift != exp_data) && (r_errCnt != 16'hFFFF)) begin
          w_errCntNext = r_errCnt + 16'd1;
        end
      end
    end

    if (err_clr) begin
      w_errCntNext   = 16'd0;
      w_frameCntNext = 16'd0;
    end
  end

  // State register for the FSM and all datapath/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_win       <= 4'd0;
      r_bitCnt    <= 2'd0;
      r_addr      <= 6'd0;
      r_miss      <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= 6'd0;
      r_wrData    <= 4'd0;
      r_frameDone <= 1'b0;
      r_lockLost  <= 1'b0;
      r_errCnt    <= 16'd0;
      r_frameCnt  <= 16'd0;
    end else begin
      r_state     <= w_stateNext;
      r_win       <= w_winNext;
      r_bitCnt    <= w_bitCntNext;
      r_addr      <= w_addrNext;
      r_miss      <= w_missNext;
      r_wrEn      <= w_wrEnNext;
      r_wrAddr    <= w_wrAddrNext;
      r_wrData    <= w_wrDataNext;
      r_frameDone <= w_frameDoneNext;
      r_lockLost  <= w_lockLostNext;
      r_errCnt    <= w_errCntNext;
      r_frameCnt  <= w_frameCntNext;
    end
  end

  assign exp_addr   = r_addr;
  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign locked     = (r_state == LOCKED);
  assign frame_done = r_frameDone;
  assign lock_lost  = r_lockLost;
  assign err_cnt    = r_errCnt;
  assign frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_sr_rx_checker.sv
// Testbench for sr_rx_checker: randomized frames checked against a
// word-level behavioural model of the receiver.
module tb_sr_rx_checker;

  localparam logic [3:0] SYNC       = 4'hA;
  localparam int         MISS_LIMIT = 2;

  logic        clk;
  logic        rst;
  logic        ser_in;
  logic        ser_valid;
  logic [3:0]  exp_data;
  logic        err_clr;
  logic [5:0]  exp_addr;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        locked;
  logic        frame_done;
  logic        lock_lost;
  logic [15:0] err_cnt;
  logic [15:0] frame_cnt;

  sr_rx_checker #(.SYNC_WORD(SYNC), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .exp_data(exp_data), .err_clr(err_clr), .exp_addr(exp_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .locked(locked),
    .frame_done(frame_done), .lock_lost(lock_lost), .err_cnt(err_cnt),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [3:0] refMem [64];

  // Behavioural model state, tracked as plain integers
  int m_win, m_bits, m_addr, m_miss, m_errCnt, m_frameCnt, m_wrAddr, m_wrData;
  bit m_locked, m_wrEn, m_frameDone, m_lockLost;

  task automatic modelReset();
    m_win = 0; m_bits = 0; m_addr = 0; m_miss = 0; m_errCnt = 0;
    m_frameCnt = 0; m_wrAddr = 0; m_wrData = 0;
    m_locked = 0; m_wrEn = 0; m_frameDone = 0; m_lockLost = 0;
  endtask

  task automatic modelEmit(input int a, input int expWord);
    m_wrEn = 1; m_wrAddr = a; m_wrData = m_win;
    if (m_win != expWord && m_errCnt < 65535) m_errCnt++;
  endtask

  task automatic modelEdge(input int b, input bit v, input bit clr, input int expWord);
    int a;
    bit lost;
    m_wrEn = 0; m_frameDone = 0; m_lockLost = 0;
    if (v) begin
      m_win = (m_win >> 1) + b * 8;
      if (!m_locked) begin
        if (m_win == int'(SYNC)) begin
          m_locked = 1; modelEmit(0, expWord);
          m_addr = 1; m_bits = 0; m_miss = 0;
        end
      end else begin
        m_bits++;
        if (m_bits == 4) begin
          m_bits = 0; a = m_addr; lost = 0;
          modelEmit(a, expWord);
          if (a == 0) begin
            if (m_win == int'(SYNC)) m_miss = 0;
            else m_miss++;
            if (m_miss >= MISS_LIMIT) begin
              lost = 1; m_miss = 0; m_locked = 0; m_lockLost = 1;
            end
          end
          if (a == 63) begin
            m_frameDone = 1; m_frameCnt = (m_frameCnt + 1) % 65536;
          end
          m_addr = lost ? 0 : (a + 1) % 64;
        end
      end
    end
    if (clr) begin m_errCnt = 0; m_frameCnt = 0; end
  endtask

  // One clock edge: drive inputs, advance model, sample #1 after the edge
  task automatic stepBit(input logic b, input logic v, input logic clr);
    exp_data  = refMem[m_addr];
    ser_in    = b;
    ser_valid = v;
    err_clr   = clr;
    modelEdge(int'(b), v, clr, int'(refMem[m_addr]));
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic sendWord(input logic [3:0] w, input int gapPct, input logic clrLast);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++)
        stepBit(1'($urandom_range(1)), 1'b0, 1'b0);
      stepBit(w[i], 1'b1, (i == 3) ? clrLast : 1'b0);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    ser_valid = 1'b0;
    err_clr = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    if (wr_en !== 1'b0) begin nMismatched++; $display("FAIL reset_wr_en: got %0h want 0", wr_en); end
    nCompared++;
    if (wr_addr !== 6'd0) begin nMismatched++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    nCompared++;
    if (wr_data !== 4'd0) begin nMismatched++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    nCompared++;
    if (locked !== 1'b0) begin nMismatched++; $display("FAIL reset_locked: got %0h want 0", locked); end
    nCompared++;
    if (frame_done !== 1'b0 || lock_lost !== 1'b0) begin
      nMismatched++; $display("FAIL reset_pulses: got %0h/%0h want 0/0", frame_done, lock_lost);
    end
    nCompared++;
    if (err_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
      nMismatched++; $display("FAIL reset_counters: got %0h/%0h want 0/0", err_cnt, frame_cnt);
    end
    nCompared++;
    if (exp_addr !== 6'd0) begin nMismatched++; $display("FAIL reset_exp_addr: got %0h want 0", exp_addr); end
    nCompared++;
    modelReset();
    rst = 1'b0;
  endtask

  task automatic test_first_lock();
    logic [3:0] bitsIn;
    refMem[0] = SYNC;
    for (int i = 1; i < 64; i++) refMem[i] = 4'($urandom_range(15));
    bitsIn = SYNC;
    for (int i = 0; i < 3; i++) begin
      stepBit(bitsIn[i], 1'b1, 1'b0);
      if (wr_en !== 1'b0 || locked !== 1'b0) begin
        nMismatched++; $display("FAIL lock_early: wr_en/locked got %0h/%0h want 0/0", wr_en, locked);
      end
      nCompared++;
    end
    stepBit(bitsIn[3], 1'b1, 1'b0);
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 4'hA) begin
      nMismatched++; $display("FAIL lock_write: got en=%0h addr=%0h data=%0h want 1/0/a", wr_en, wr_addr, wr_data);
    end
    nCompared++;
    if (locked !== 1'b1 || exp_addr !== 6'd1 || err_cnt !== 16'd0) begin
      nMismatched++; $display("FAIL lock_state: got locked=%0h exp_addr=%0h err=%0h want 1/1/0", locked, exp_addr, err_cnt);
    end
    nCompared++;
  endtask

  task automatic test_frames();
    int pulses = 0;
    int dones  = 0;
    for (int n = 1; n < 128; n++) begin
      sendWord(refMem[n % 64], 0, 1'b0);
      if (wr_en) pulses++;
      if (frame_done) dones++;
      if (wr_en !== m_wrEn || wr_addr !== 6'(m_wrAddr) || wr_data !== 4'(m_wrData) || wr_addr !== 6'(n % 64)) begin
        nMismatched++; $display("FAIL frame_word%0d: got en=%0h addr=%0h data=%0h want 1/%0h/%0h", n, wr_en, wr_addr, wr_data, n % 64, refMem[n % 64]);
      end
      nCompared++;
      if (frame_done !== m_frameDone) begin
        nMismatched++; $display("FAIL frame_done%0d: got %0h want %0h", n, frame_done, m_frameDone);
      end
      nCompared++;
    end
    if (pulses + 1 !== 128 || dones !== 2) begin
      nMismatched++; $display("FAIL frame_totals: got pulses=%0d dones=%0d want 128/2", pulses + 1, dones);
    end
    nCompared++;
    if (frame_cnt !== 16'd2 || err_cnt !== 16'd0 || locked !== 1'b1) begin
      nMismatched++; $display("FAIL frame_counters: got fc=%0h err=%0h locked=%0h want 2/0/1", frame_cnt, err_cnt, locked);
    end
    nCompared++;
  endtask

  task automatic test_mismatch();
    refMem[5] = 4'h5;
    for (int n = 0; n < 64; n++) begin
      sendWord((n == 5) ? 4'h3 : refMem[n], 0, 1'b0);
      if (n == 5) begin
        if (err_cnt !== 16'd1 || 32'(err_cnt) !== m_errCnt || locked !== 1'b1 || wr_data !== 4'h3) begin
          nMismatched++; $display("FAIL mismatch_word: got err=%0h locked=%0h data=%0h want 1/1/3", err_cnt, locked, wr_data);
        end
        nCompared++;
      end
    end
    if (err_cnt !== 16'd1 || frame_cnt !== 16'(m_frameCnt)) begin
      nMismatched++; $display("FAIL mismatch_end: got err=%0h fc=%0h want 1/%0h", err_cnt, frame_cnt, m_frameCnt);
    end
    nCompared++;
  endtask

  task automatic test_lock_loss();
    logic [3:0] bitsIn;
    sendWord(4'h5, 0, 1'b0);
    if (locked !== 1'b1 || lock_lost !== 1'b0 || wr_data !== 4'h5) begin
      nMismatched++; $display("FAIL loss_first_bad: got locked=%0h lost=%0h data=%0h want 1/0/5", locked, lock_lost, wr_data);
    end
    nCompared++;
    for (int n = 1; n < 64; n++) sendWord(refMem[n], 0, 1'b0);
    sendWord(4'h5, 0, 1'b0);
    if (lock_lost !== 1'b1 || locked !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 4'h5) begin
      nMismatched++; $display("FAIL loss_second_bad: got lost=%0h locked=%0h en=%0h addr=%0h data=%0h want 1/0/1/0/5",
                              lock_lost, locked, wr_en, wr_addr, wr_data);
    end
    nCompared++;
    if (32'(err_cnt) !== m_errCnt || exp_addr !== 6'd0) begin
      nMismatched++; $display("FAIL loss_counts: got err=%0h exp_addr=%0h want %0h/0", err_cnt, exp_addr, m_errCnt);
    end
    nCompared++;
    bitsIn = SYNC;
    for (int i = 0; i < 4; i++) begin
      stepBit(bitsIn[i], 1'b1, 1'b0);
      if (lock_lost !== 1'b0 || locked !== m_locked || wr_en !== m_wrEn) begin
        nMismatched++; $display("FAIL relock_bit%0d: got lost=%0h locked=%0h en=%0h want 0/%0h/%0h", i, lock_lost, locked, wr_en, m_locked, m_wrEn);
      end
      nCompared++;
    end
    if (locked !== 1'b1 || wr_data !== 4'hA || wr_addr !== 6'd0) begin
      nMismatched++; $display("FAIL relock: got locked=%0h data=%0h addr=%0h want 1/a/0", locked, wr_data, wr_addr);
    end
    nCompared++;
  endtask

  task automatic test_err_clr();
    sendWord(~refMem[1], 0, 1'b1);
    if (err_cnt !== 16'd0 || frame_cnt !== 16'd0 || wr_en !== 1'b1) begin
      nMismatched++; $display("FAIL clr_priority: got err=%0h fc=%0h en=%0h want 0/0/1", err_cnt, frame_cnt, wr_en);
    end
    nCompared++;
    force dut.r_errCnt = 16'hFFFD;
    #1;
    release dut.r_errCnt;
    m_errCnt = 32'hFFFD;
    for (int n = 2; n < 6; n++) begin
      sendWord(~refMem[n], 0, 1'b0);
      if (32'(err_cnt) !== m_errCnt) begin
        nMismatched++; $display("FAIL saturate_step%0d: got %0h want %0h", n, err_cnt, m_errCnt);
      end
      nCompared++;
    end
    if (err_cnt !== 16'hFFFF || locked !== 1'b1) begin
      nMismatched++; $display("FAIL saturate_final: got err=%0h locked=%0h want ffff/1", err_cnt, locked);
    end
    nCompared++;
  endtask

  task automatic test_gaps_and_reset();
    logic [3:0] bitsIn;
    for (int n = 6; n < 20; n++) begin
      sendWord(refMem[n], 40, 1'b0);
      if (wr_en !== m_wrEn || wr_addr !== 6'(m_wrAddr) || wr_data !== refMem[n] || 32'(err_cnt) !== m_errCnt) begin
        nMismatched++; $display("FAIL gap_word%0d: got en=%0h addr=%0h data=%0h want 1/%0h/%0h", n, wr_en, wr_addr, wr_data, n, refMem[n]);
      end
      nCompared++;
      stepBit(1'($urandom_range(1)), 1'b0, 1'b0);
      if (wr_en !== 1'b0 || wr_addr !== 6'(n) || exp_addr !== 6'(m_addr)) begin
        nMismatched++; $display("FAIL gap_hold%0d: got en=%0h addr=%0h exp_addr=%0h want 0/%0h/%0h", n, wr_en, wr_addr, exp_addr, n, m_addr);
      end
      nCompared++;
    end
    stepBit(1'b1, 1'b1, 1'b0);
    stepBit(1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    if (locked !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 4'd0 || exp_addr !== 6'd0) begin
      nMismatched++; $display("FAIL midreset_outputs: got locked=%0h en=%0h addr=%0h data=%0h exp_addr=%0h want all 0",
                              locked, wr_en, wr_addr, wr_data, exp_addr);
    end
    nCompared++;
    if (err_cnt !== 16'd0 || frame_cnt !== 16'd0 || frame_done !== 1'b0 || lock_lost !== 1'b0) begin
      nMismatched++; $display("FAIL midreset_counters: got err=%0h fc=%0h done=%0h lost=%0h want all 0",
                              err_cnt, frame_cnt, frame_done, lock_lost);
    end
    nCompared++;
    applyReset();
    if (lock_lost !== 1'b0 || locked !== 1'b0) begin
      nMismatched++; $display("FAIL postreset: got lost=%0h locked=%0h want 0/0", lock_lost, locked);
    end
    nCompared++;
    bitsIn = SYNC;
    for (int i = 0; i < 4; i++) stepBit(bitsIn[i], 1'b1, 1'b0);
    if (locked !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 4'hA) begin
      nMismatched++; $display("FAIL reset_relock: got locked=%0h en=%0h addr=%0h data=%0h want 1/1/0/a", locked, wr_en, wr_addr, wr_data);
    end
    nCompared++;
  endtask

  initial begin
    rst = 1'b1;
    ser_in = 1'b0;
    ser_valid = 1'b0;
    err_clr = 1'b0;
    exp_data = 4'd0;
    for (int i = 0; i < 64; i++) refMem[i] = 4'd0;
    modelReset();
    test_reset();
    test_first_lock();
    test_frames();
    test_mismatch();
    test_lock_loss();
    test_err_clr();
    test_gaps_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
